// File: rtl/debug_uart_rx_if.sv
// CPU-side register interface of the debug UART receiver: read/clear strobes
// from the CPU, FIFO head, status and interrupt back to it.
interface debug_uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_pop;
  logic          err_clear;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          overrun;
  logic          frame_error;
  logic          rx_busy;
  logic          interrupt;

  modport master (
    output rx_pop, err_clear,
    input  rx_data, rx_valid, rx_count, overrun, frame_error, rx_busy, interrupt
  );

  modport slave (
    input  rx_pop, err_clear,
    output rx_data, rx_valid, rx_count, overrun, frame_error, rx_busy, interrupt
  );
endinterface

// File: rtl/debug_uart_rx.sv
// 8N1 receiver for the debug UART: oversampled mid-bit recovery, small receive
// FIFO, sticky overrun/framing flags and a level interrupt while data is pending.
module debug_uart_rx #(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  debug_uart_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CW           = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CW_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CW_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CW_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic             sync1_r;
  logic             rxd_sync_r;
  logic [1:0]       sync_vld_r;
  logic             armed_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             busy_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overrun_r;
  logic             ferr_r;

  logic push_s;
  logic ferr_set_s;
  logic full_s;
  logic pop_s;
  logic wr_en_s;
  logic ovr_set_s;

  // Two-flop synchronizer; the reset-value ones must not arm the receiver, so
  // arming waits until rxd_sync_r carries a genuine pin sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b1;
      rxd_sync_r <= 1'b1;
      sync_vld_r <= 2'b00;
      armed_r    <= 1'b0;
    end else begin
      sync1_r    <= uart_rxd;
      rxd_sync_r <= sync1_r;
      sync_vld_r <= {sync_vld_r[0], 1'b1};
      if (sync_vld_r[1] && rxd_sync_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Stop-bit outcome and FIFO write/overrun decisions for the current cycle.
  always_comb begin
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    if ((state_r == STOP) && (cnt_r == CNT_ZERO)) begin
      push_s     = rxd_sync_r;
      ferr_set_s = ~rxd_sync_r;
    end else begin
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
    end
    full_s    = (count_r == CW_FULL);
    pop_s     = bus.rx_pop && (count_r != CW_ZERO);
    wr_en_s   = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
  end

  // Receive state machine: mid-bit sampling of start, 8 data bits and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (armed_r && !rxd_sync_r) begin
            state_r <= START;
            cnt_r   <= CNT_HALF;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == CNT_ZERO) begin
            if (!rxd_sync_r) begin
              state_r   <= DATA;
              cnt_r     <= CNT_BIT;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == CNT_ZERO) begin
            shift_r   <= {rxd_sync_r, shift_r[7:1]};
            cnt_r     <= CNT_BIT;
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == CNT_ZERO) begin
            if (rxd_sync_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        BREAK: begin
          if (rxd_sync_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a pop on a full FIFO frees the slot for a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CW_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW_ONE;
        2'b01:   count_r <= count_r - CW_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the head when count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (bus.err_clear) begin
        overrun_r <= 1'b0;
      end
      if (ferr_set_s) begin
        ferr_r <= 1'b1;
      end else if (bus.err_clear) begin
        ferr_r <= 1'b0;
      end
    end
  end

  assign bus.rx_valid    = (count_r != CW_ZERO);
  assign bus.interrupt   = (count_r != CW_ZERO);
  assign bus.rx_count    = count_r;
  assign bus.rx_data     = (count_r != CW_ZERO) ? mem_r[rd_ptr_r] : 8'h00;
  assign bus.overrun     = overrun_r;
  assign bus.frame_error = ferr_r;
  assign bus.rx_busy     = busy_r;
endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: serial frames are generated bit by bit,
// expected bytes go into a scoreboard queue and are compared as the CPU pops them.
module tb_debug_uart_rx;
  logic clk = 1'b0;
  logic rst;
  logic uart_rxd;

  always #5 clk = ~clk;

  debug_uart_rx_if #(.FIFO_DEPTH(4)) bus();

  debug_uart_rx #(
    .CLK_HZ    (27_000_000),
    .BIT_RATE  (1_000_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rxd(uart_rxd),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         cpb;
    logic [2:0] exp_count;
    logic       exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  logic [7:0] head_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb);
    uart_rxd = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (cpb) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.rx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.rx_busy, 1'b0);
  endtask

  task automatic pulse_pop();
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({name, "_valid"}, bus.rx_valid, 1'b1);
    check({name, "_data"}, bus.rx_data, e);
    pulse_pop();
  endtask

  task automatic check_empty(input string name);
    check({name, "_valid"}, bus.rx_valid, 1'b0);
    check({name, "_count"}, bus.rx_count, 3'd0);
    check({name, "_data"}, bus.rx_data, 8'h00);
    check({name, "_irq"}, bus.interrupt, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hC3, 26, 3'd1, 1'b0};
    vecs[1] = '{8'hC3, 28, 3'd1, 1'b0};
    vecs[2] = '{8'h5A, 27, 3'd1, 1'b0};
    vecs[3] = '{8'h01, 27, 3'd1, 1'b0};
    vecs[4] = '{8'h80, 27, 3'd1, 1'b0};
    vecs[5] = '{8'hFE, 26, 3'd1, 1'b0};

    rst = 1'b1;
    uart_rxd = 1'b1;
    bus.rx_pop = 1'b0;
    bus.err_clear = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_empty("reset");
    check("reset_ovr", bus.overrun, 1'b0);
    check("reset_ferr", bus.frame_error, 1'b0);
    check("reset_busy", bus.rx_busy, 1'b0);
    idle(10);

    // Single byte with latency measurement from the falling edge.
    lat = 0;
    fork
      send_byte(8'hA5, 27);
      begin
        while (!bus.rx_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    exp_q.push_back(8'hA5);
    check("a5_latency_window", (lat >= 250 && lat <= 262), 1'b1);
    check("a5_count", bus.rx_count, 3'd1);
    check("a5_irq", bus.interrupt, 1'b1);
    pop_check("a5");
    check_empty("a5_after_pop");

    // Table-driven single frames, including baud tolerance at 26 and 28 clocks/bit.
    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].data, vecs[v].cpb);
      exp_q.push_back(vecs[v].data);
      wait_idle("vec_idle");
      check("vec_count", bus.rx_count, vecs[v].exp_count);
      check("vec_ferr", bus.frame_error, vecs[v].exp_ferr);
      pop_check("vec");
      check("vec_count_after", bus.rx_count, 3'd0);
    end
    idle(5);

    // Back-to-back burst fills the FIFO, a fifth byte overruns.
    send_byte(8'h00, 27); exp_q.push_back(8'h00);
    send_byte(8'hFF, 27); exp_q.push_back(8'hFF);
    send_byte(8'h55, 27); exp_q.push_back(8'h55);
    send_byte(8'h3C, 27); exp_q.push_back(8'h3C);
    check("burst_count", bus.rx_count, 3'd4);
    check("burst_ovr", bus.overrun, 1'b0);
    check("burst_ferr", bus.frame_error, 1'b0);
    send_byte(8'h99, 27);
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_count", bus.rx_count, 3'd4);
    check("ovr_head", bus.rx_data, exp_q[0]);
    pulse_clear();
    check("ovr_cleared", bus.overrun, 1'b0);

    // Full FIFO with a pop on the stop-sample cycle of the next byte.
    fork
      send_byte(8'h81, 27);
      begin
        repeat (258) @(negedge clk);
        check("simul_pre_count", bus.rx_count, 3'd4);
        head_e = exp_q.pop_front();
        check("simul_head", bus.rx_data, head_e);
        pulse_pop();
      end
    join
    exp_q.push_back(8'h81);
    check("simul_ovr", bus.overrun, 1'b0);
    check("simul_count", bus.rx_count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      pop_check("drain");
    end
    check_empty("drain_done");
    idle(5);

    // Short glitch is rejected silently.
    uart_rxd = 1'b0;
    repeat (8) @(negedge clk);
    idle(40);
    check("glitch_busy", bus.rx_busy, 1'b0);
    check("glitch_count", bus.rx_count, 3'd0);
    check("glitch_ferr", bus.frame_error, 1'b0);

    // Break: one framing error, no further ones while held low, no byte.
    uart_rxd = 1'b0;
    repeat (540) @(negedge clk);
    check("break_ferr", bus.frame_error, 1'b1);
    check("break_busy", bus.rx_busy, 1'b1);
    check("break_count", bus.rx_count, 3'd0);
    pulse_clear();
    repeat (100) @(negedge clk);
    check("break_no_reset", bus.frame_error, 1'b0);
    idle(10);
    check("break_exit_busy", bus.rx_busy, 1'b0);
    check("break_exit_ferr", bus.frame_error, 1'b0);
    send_byte(8'h42, 27);
    exp_q.push_back(8'h42);
    wait_idle("b42_idle");
    pop_check("b42");
    idle(5);

    // Reset in the middle of a data phase with a byte already buffered.
    send_byte(8'h11, 27);
    check("pre_rst_count", bus.rx_count, 3'd1);
    uart_rxd = 1'b0;
    repeat (81) @(negedge clk);
    check("mid_busy", bus.rx_busy, 1'b1);
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_empty("mid_rst");
    check("mid_rst_busy", bus.rx_busy, 1'b0);
    idle(300);
    check("mid_rst_later_count", bus.rx_count, 3'd0);
    check("mid_rst_later_ferr", bus.frame_error, 1'b0);

    // Line held low through reset release must not start a frame.
    rst = 1'b1;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("held_busy", bus.rx_busy, 1'b0);
    check("held_count", bus.rx_count, 3'd0);
    check("held_ferr", bus.frame_error, 1'b0);
    idle(30);
    send_byte(8'h7E, 27);
    exp_q.push_back(8'h7E);
    wait_idle("b7e_idle");
    check("b7e_count", bus.rx_count, 3'd1);
    pop_check("b7e");
    check_empty("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
